// File: rtl/imager_pattern_gen.sv
// Imager test-pattern source: frame/line timing with bayer flat-field, ramp,
// per-lane LFSR noise and checkerboard patterns on a LANES-wide pixel bus.
module imager_pattern_gen #(
    parameter int DATA_WIDTH     = 10,
    parameter int LANES          = 2,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [DATA_WIDTH-1:0]       bayer_red,
    input  logic [DATA_WIDTH-1:0]       bayer_gr,
    input  logic [DATA_WIDTH-1:0]       bayer_gb,
    input  logic [DATA_WIDTH-1:0]       bayer_blue,
    input  logic [NUM_ROWS_WIDTH-1:0]   num_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]   num_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0]   num_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0]   num_virtual_cols,
    input  logic [NUM_ROWS_WIDTH-1:0]   sync_row_start,
    input  logic [NUM_ROWS_WIDTH-1:0]   sync_rows,
    input  logic [31:0]                 noise_seed,
    output logic [LANES*DATA_WIDTH-1:0] dat,
    output logic                        fv,
    output logic                        lv,
    output logic                        sync,
    output logic [15:0]                 frame_count
);
    localparam int          CW        = NUM_COLS_WIDTH + 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;

    state_t                      state;
    logic [NUM_ROWS_WIDTH-1:0]   row;
    logic [CW-1:0]               col;

    logic [1:0]                  mode_s;
    logic [DATA_WIDTH-1:0]       red_s, gr_s, gb_s, blue_s;
    logic [NUM_ROWS_WIDTH-1:0]   act_rows_s, blank_rows_s, sync_start_s, sync_rows_s;
    logic [CW-1:0]               act_cyc_s, line_len_s;

    logic [31:0]                 lfsr [LANES];

    logic                        vld_p0, fv_p0, sync_p0;
    logic [NUM_ROWS_WIDTH-1:0]   y_p0;
    logic [CW-1:0]               col_p0;

    logic [CW-1:0]               act_cyc_in;
    logic                        cfg_ok, line_end, last_blank_row, load_frame, sync_now;
    logic [LANES*DATA_WIDTH-1:0] dat_nxt;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input int k);
        logic [31:0] s;
        s = seed + 32'(k);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pixel_val(
        input logic [1:0]            m,
        input logic [31:0]           y,
        input logic [31:0]           p,
        input logic [DATA_WIDTH-1:0] rnd,
        input logic [DATA_WIDTH-1:0] r,
        input logic [DATA_WIDTH-1:0] g_r,
        input logic [DATA_WIDTH-1:0] g_b,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [31:0] sum;
        sum = y + p;
        case (m)
            2'd0:    pixel_val = y[0] ? (p[0] ? b : g_b) : (p[0] ? g_r : r);
            2'd1:    pixel_val = sum[DATA_WIDTH-1:0];
            2'd2:    pixel_val = rnd;
            default: pixel_val = (y[3] ^ p[3]) ? '1 : '0;
        endcase
    endfunction

    assign act_cyc_in     = CW'(num_active_cols / NUM_COLS_WIDTH'(LANES));
    assign cfg_ok         = (num_active_rows != '0) && (num_active_cols >= NUM_COLS_WIDTH'(LANES));
    assign line_end       = (col == line_len_s - CW'(1));
    // A zero blank-row count still yields one blank row between frames.
    assign last_blank_row = (blank_rows_s == '0) || (row == blank_rows_s - NUM_ROWS_WIDTH'(1));
    assign load_frame     = enable && cfg_ok &&
                            ((state == IDLE) || ((state == VBLANK) && line_end && last_blank_row));
    assign sync_now       = (state == VBLANK) && (sync_rows_s != '0) && (row >= sync_start_s) &&
                            ((row - sync_start_s) < sync_rows_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else if (load_frame) begin
            state <= ACTIVE;
            row   <= '0;
            col   <= '0;
        end else if (state != IDLE) begin
            if (!line_end) begin
                col <= col + CW'(1);
            end else begin
                col <= '0;
                if ((state == ACTIVE) && (row == act_rows_s - NUM_ROWS_WIDTH'(1))) begin
                    state <= VBLANK;
                    row   <= '0;
                end else if ((state == VBLANK) && last_blank_row) begin
                    state <= IDLE;
                    row   <= '0;
                end else begin
                    row <= row + NUM_ROWS_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_frame) begin
            mode_s       <= mode;
            red_s        <= bayer_red;
            gr_s         <= bayer_gr;
            gb_s         <= bayer_gb;
            blue_s       <= bayer_blue;
            act_rows_s   <= num_active_rows;
            blank_rows_s <= num_virtual_rows;
            sync_start_s <= sync_row_start;
            sync_rows_s  <= sync_rows;
            act_cyc_s    <= act_cyc_in;
            line_len_s   <= act_cyc_in + CW'(num_virtual_cols);
        end
    end

    // The generator advances only on cycles whose pixels reach the output.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (load_frame) begin
                lfsr[k] <= lfsr_seed(noise_seed, k);
            end else if (vld_p0) begin
                lfsr[k] <= lfsr_step(lfsr[k]);
            end
        end
    end

    // Stage p0: timing decode
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            fv_p0   <= 1'b0;
            sync_p0 <= 1'b0;
        end else begin
            vld_p0  <= (state == ACTIVE) && (col < act_cyc_s);
            fv_p0   <= (state == ACTIVE);
            sync_p0 <= sync_now;
        end
    end

    always_ff @(posedge clk) begin
        y_p0   <= row;
        col_p0 <= col;
    end

    always_comb begin
        dat_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            dat_nxt[k*DATA_WIDTH +: DATA_WIDTH] =
                pixel_val(mode_s, 32'(y_p0), 32'(col_p0) * 32'(LANES) + 32'(k),
                          lfsr[k][DATA_WIDTH-1:0], red_s, gr_s, gb_s, blue_s);
        end
    end

    // Stage p1: registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            dat         <= '0;
            fv          <= 1'b0;
            lv          <= 1'b0;
            sync        <= 1'b0;
            frame_count <= '0;
        end else begin
            dat  <= vld_p0 ? dat_nxt : '0;
            lv   <= vld_p0;
            fv   <= fv_p0;
            sync <= sync_p0;
            if (fv && !fv_p0) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_imager_pattern_gen.sv
// Randomised self-checking bench for imager_pattern_gen with a frame-level reference model.
module tb_imager_pattern_gen;
    localparam int DW = 10;
    localparam int LN = 2;
    localparam int RW = 12;
    localparam int CWD = 12;

    logic              clk = 1'b0;
    logic              reset, enable;
    logic [1:0]        mode;
    logic [DW-1:0]     bayer_red, bayer_gr, bayer_gb, bayer_blue;
    logic [RW-1:0]     num_active_rows, num_virtual_rows, sync_row_start, sync_rows;
    logic [CWD-1:0]    num_active_cols, num_virtual_cols;
    logic [31:0]       noise_seed;
    logic [LN*DW-1:0]  dat;
    logic              fv, lv, sync;
    logic [15:0]       frame_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    mode;
        logic [DW-1:0] r, gr, gb, b;
        int            rows, vrows, acols, vcols, sstart, srows;
        logic [31:0]   seed;
    } cfg_t;

    imager_pattern_gen #(.DATA_WIDTH(DW), .LANES(LN), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CWD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .bayer_red(bayer_red), .bayer_gr(bayer_gr), .bayer_gb(bayer_gb), .bayer_blue(bayer_blue),
        .num_active_rows(num_active_rows), .num_virtual_rows(num_virtual_rows),
        .num_active_cols(num_active_cols), .num_virtual_cols(num_virtual_cols),
        .sync_row_start(sync_row_start), .sync_rows(sync_rows), .noise_seed(noise_seed),
        .dat(dat), .fv(fv), .lv(lv), .sync(sync), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic cfg_t mk(input int md, input int rows, input int vrows, input int acols,
                                input int vcols, input int sstart, input int srows, input logic [31:0] seed);
        cfg_t c;
        c.mode = 2'(md); c.r = 10'h3FF; c.gr = 10'h100; c.gb = 10'h200; c.b = 10'h001;
        c.rows = rows; c.vrows = vrows; c.acols = acols; c.vcols = vcols;
        c.sstart = sstart; c.srows = srows; c.seed = seed;
        return c;
    endfunction

    function automatic int period(input cfg_t c);
        int vr;
        vr = (c.vrows == 0) ? 1 : c.vrows;
        return (c.rows + vr) * (c.acols / LN + c.vcols);
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic logic [DW-1:0] ref_pix(input cfg_t c, input int y, input int p, input logic [31:0] rnd);
        case (c.mode)
            2'd0: begin
                if (y % 2 == 0) return (p % 2 == 0) ? c.r : c.gr;
                else            return (p % 2 == 0) ? c.gb : c.b;
            end
            2'd1:    return DW'((y + p) % (1 << DW));
            2'd2:    return rnd[DW-1:0];
            default: return (((y / 8) % 2) != ((p / 8) % 2)) ? {DW{1'b1}} : {DW{1'b0}};
        endcase
    endfunction

    task automatic apply_cfg(input cfg_t c);
        mode = c.mode; bayer_red = c.r; bayer_gr = c.gr; bayer_gb = c.gb; bayer_blue = c.b;
        num_active_rows = RW'(c.rows); num_virtual_rows = RW'(c.vrows);
        num_active_cols = CWD'(c.acols); num_virtual_cols = CWD'(c.vcols);
        sync_row_start = RW'(c.sstart); sync_rows = RW'(c.srows); noise_seed = c.seed;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Enables the DUT (in IDLE) and checks every output cycle against the frame model.
    task automatic run_stream(input cfg_t c0, input cfg_t c1, input int change_at, input int drop_at,
                              input int max_frames, input int ncyc, input int fc_base, input string tag);
        logic [31:0] lf [LN];
        int model_frame = -1;
        apply_cfg(c0);
        enable = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            int n, f, fs, i, y, cc, r, acyc, lcyc;
            cfg_t c;
            logic e_fv, e_lv, e_sync;
            logic [LN*DW-1:0] e_dat;
            logic [15:0] e_fc;
            @(negedge clk);
            n = j - 2;
            e_fv = 1'b0; e_lv = 1'b0; e_sync = 1'b0; e_dat = '0; e_fc = 16'(fc_base);
            if (n >= 0) begin
                f = 0; fs = 0; c = c0;
                while (f < max_frames && n >= fs + period(c)) begin
                    fs = fs + period(c);
                    f++;
                    c = c1;
                end
                if (f >= max_frames) begin
                    e_fc = 16'(fc_base + max_frames);
                end else begin
                    i = n - fs; acyc = c.acols / LN; lcyc = acyc + c.vcols;
                    if (i < c.rows * lcyc) begin
                        y = i / lcyc; cc = i % lcyc;
                        e_fv = 1'b1; e_fc = 16'(fc_base + f);
                        if (cc < acyc) begin
                            e_lv = 1'b1;
                            if (model_frame != f) begin
                                for (int k = 0; k < LN; k++) begin
                                    lf[k] = c.seed + 32'(k);
                                    if (lf[k] == 32'd0) lf[k] = 32'd1;
                                end
                                model_frame = f;
                            end
                            for (int k = 0; k < LN; k++) begin
                                e_dat[k*DW +: DW] = ref_pix(c, y, cc * LN + k, lf[k]);
                                lf[k] = ref_step(lf[k]);
                            end
                        end
                    end else begin
                        r = (i - c.rows * lcyc) / lcyc;
                        e_fc = 16'(fc_base + f + 1);
                        e_sync = (c.srows != 0) && (r >= c.sstart) && (r < c.sstart + c.srows);
                    end
                end
            end
            checks++;
            if ({fv, lv, sync, dat, frame_count} !== {e_fv, e_lv, e_sync, e_dat, e_fc}) begin
                errors++;
                $display("FAIL %s n=%0d got fv=%b lv=%b sync=%b dat=%h fc=%0d exp fv=%b lv=%b sync=%b dat=%h fc=%0d",
                         tag, n, fv, lv, sync, dat, frame_count, e_fv, e_lv, e_sync, e_dat, e_fc);
            end
            if (j == change_at) apply_cfg(c1);
            if (j == drop_at) enable = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        apply_cfg(mk(0, 4, 2, 8, 3, 0, 0, 0));
        @(negedge clk); @(negedge clk);
        checks++;
        if ({fv, lv, sync, dat, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_state got fv=%b lv=%b sync=%b dat=%h fc=%0d exp all 0", fv, lv, sync, dat, frame_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_timing();
        cfg_t c;
        int fv_hi = 0, lv_hi = 0, first = -1;
        c = mk(1, 4, 2, 8, 3, 0, 0, 0);
        do_reset();
        apply_cfg(c);
        enable = 1'b1;
        for (int j = 0; j < 44; j++) begin
            @(negedge clk);
            if (fv) fv_hi++;
            if (lv) lv_hi++;
            if (fv && first < 0) first = j;
        end
        checks++; if (fv_hi != 28) begin errors++; $display("FAIL fv_high got %0d exp 28", fv_hi); end
        checks++; if (lv_hi != 16) begin errors++; $display("FAIL lv_high got %0d exp 16", lv_hi); end
        checks++; if (first != 2) begin errors++; $display("FAIL fv_latency got %0d exp 2", first); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL frame_count got %0d exp 1", frame_count); end
        do_reset();
        run_stream(c, c, -1, -1, 100, 110, 0, "timing");
    endtask

    task automatic test_bayer();
        cfg_t c;
        logic [LN*DW-1:0] exp0, exp1;
        exp0 = {10'h100, 10'h3FF};
        exp1 = {10'h001, 10'h200};
        c = mk(0, 4, 2, 8, 3, 0, 0, 0);
        do_reset();
        apply_cfg(c);
        enable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 2) begin
                checks++;
                if (dat !== exp0) begin errors++; $display("FAIL bayer_row0 got %h exp %h", dat, exp0); end
            end
            if (j == 9) begin
                checks++;
                if (dat !== exp1) begin errors++; $display("FAIL bayer_row1 got %h exp %h", dat, exp1); end
            end
        end
        do_reset();
        run_stream(c, c, -1, -1, 100, 90, 0, "bayer");
    endtask

    task automatic test_ramp_checker();
        cfg_t c;
        c = mk(1, 4, 1, 8, 2, 0, 0, 0);
        do_reset();
        run_stream(c, c, -1, -1, 100, 70, 0, "ramp");
        c = mk(3, 16, 1, 16, 0, 0, 0, 0);
        do_reset();
        run_stream(c, c, -1, -1, 100, 280, 0, "checker");
    endtask

    task automatic test_sync_noise();
        cfg_t c;
        int sync_hi = 0;
        logic [DW-1:0] first_px = '0;
        c = mk(2, 3, 4, 8, 2, 1, 5, 32'd0);
        do_reset();
        apply_cfg(c);
        enable = 1'b1;
        for (int j = 0; j < 44; j++) begin
            @(negedge clk);
            if (sync) sync_hi++;
            if (j == 2) first_px = dat[DW-1:0];
        end
        checks++; if (sync_hi != 18) begin errors++; $display("FAIL sync_cycles got %0d exp 18", sync_hi); end
        checks++; if (first_px !== 10'd1) begin errors++; $display("FAIL noise_first got %0d exp 1", first_px); end
        do_reset();
        run_stream(c, c, -1, -1, 100, 95, 0, "sync_noise");
    endtask

    task automatic test_enable_drop();
        cfg_t c;
        c = mk(1, 4, 2, 8, 3, 0, 0, 0);
        do_reset();
        run_stream(c, c, -1, 18, 1, 80, 0, "enable_drop");
        run_stream(c, c, -1, -1, 100, 50, 1, "reenable");
    endtask

    task automatic test_invalid();
        do_reset();
        run_stream(mk(1, 0, 2, 8, 3, 0, 2, 0), mk(1, 0, 2, 8, 3, 0, 2, 0), -1, -1, 0, 40, 0, "rows_zero");
        do_reset();
        run_stream(mk(1, 2, 1, 1, 3, 0, 2, 0), mk(1, 2, 1, 1, 3, 0, 2, 0), -1, -1, 0, 40, 0, "cols_small");
    endtask

    task automatic test_mode_change();
        cfg_t c0, c1;
        c0 = mk(1, 3, 1, 8, 2, 0, 0, 0);
        c1 = mk(3, 2, 2, 8, 2, 0, 1, 0);
        c1.r = 10'h055;
        do_reset();
        run_stream(c0, c1, 5, -1, 100, 2 + period(c0) + 2 * period(c1) + 4, 0, "mode_change");
    endtask

    task automatic test_reset_mid();
        cfg_t c;
        c = mk(2, 3, 1, 8, 2, 0, 0, $urandom);
        do_reset();
        run_stream(c, c, -1, -1, 100, 34, 0, "pre_reset");
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({fv, lv, sync, dat, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid got fv=%b lv=%b sync=%b dat=%h fc=%0d exp all 0", fv, lv, sync, dat, frame_count);
        end
        reset = 1'b0;
        run_stream(c, c, -1, -1, 100, 40, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            cfg_t c0, c1;
            c0 = mk($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 3), LN * $urandom_range(1, 6),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
            c1 = mk($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 3), LN * $urandom_range(1, 6),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
            c0.r = DW'($urandom); c0.gr = DW'($urandom); c0.gb = DW'($urandom); c0.b = DW'($urandom);
            c1.r = DW'($urandom); c1.gr = DW'($urandom); c1.gb = DW'($urandom); c1.b = DW'($urandom);
            do_reset();
            run_stream(c0, c1, 0, -1, 100, 2 + period(c0) + period(c1) + 5, 0, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        test_reset();
        test_timing();
        test_bayer();
        test_ramp_checker();
        test_sync_noise();
        test_enable_drop();
        test_invalid();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
